quad_steer_gen: RTL
===================

QUAD_STEER_GEN -- requirements
Module: quad_steer_gen

Interface
REQ-001 The module SHALL have parameter CHANNELS, default 2, giving the number of independent encoder channels (1..8).
REQ-002 The module SHALL have parameter DIV_W, default 16, giving the width of the step-period divider.
REQ-003 The module SHALL have parameter POS_W, default 8, giving the width of each tracked position.
REQ-004 The module SHALL have port clk_sys, input, 1 bit: system clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port clkdiv, input, DIV_W bits: step period in clk_sys cycles; 0 is treated as 1.
REQ-007 The module SHALL have port mode, input, 2 bits: 0 = digital, 1 = absolute, 2 or 3 = hold.
REQ-008 The module SHALL have port left, input, CHANNELS bits: per-channel decrement request, active-high.
REQ-009 The module SHALL have port right, input, CHANNELS bits: per-channel increment request, active-high.
REQ-010 The module SHALL have port target, input, CHANNELS*POS_W bits: per-channel absolute target; channel n occupies bits [n*POS_W +: POS_W].
REQ-011 The module SHALL have port enc_a, output, CHANNELS bits: quadrature A per channel.
REQ-012 The module SHALL have port enc_b, output, CHANNELS bits: quadrature B per channel.
REQ-013 The module SHALL have port pos, output, CHANNELS*POS_W bits: per-channel tracked position, packed like target.
REQ-014 The module SHALL have port busy, output, 1 bit: OR over all channels of "stepping active this cycle".

Function
REQ-015 Each channel SHALL hold a DIV_W-bit tick counter, a 2-bit phase, a POS_W-bit position and a direction request, all independent of the other channels.
REQ-016 A channel's direction request SHALL be as follows: digital mode gives +1 when right&~left and -1 when left&~right; absolute mode gives +1 when pos<target and -1 when pos>target; otherwise the request is 0.
REQ-017 When a channel's request is 0, its tick counter SHALL be held at 0 and its phase and pos SHALL not change.
REQ-018 When a channel's request is nonzero, its counter SHALL increment each cycle; at counter == effdiv-1 it SHALL wrap to 0 and issue one step.
REQ-019 A +1 step SHALL advance phase 00->01->11->10->00 and a -1 step SHALL advance it in reverse.
REQ-020 The outputs SHALL be registered as enc_a = phase[1] and enc_b = phase[0], with exactly one output bit changing per step.
REQ-021 Each step SHALL change pos by +/-1; digital mode SHALL wrap pos modulo 2^POS_W, and absolute mode SHALL stop exactly at target with no overshoot.
REQ-022 The first output change SHALL occur on the effdiv-th rising edge after the request is first sampled nonzero; a continuous request SHALL produce one step every effdiv cycles.
REQ-023 Without acceleration, effdiv SHALL equal max(clkdiv,1).
REQ-024 A direction reversal while the counter is nonzero SHALL reset the counter to 0 and SHALL not issue a step that cycle.
REQ-025 A change of mode SHALL reset all tick counters to 0, while phase and pos SHALL be retained.
REQ-026 A change of target in absolute mode SHALL take effect on the next cycle, with no step loss or double step.
REQ-027 In hold mode every request SHALL be 0.
REQ-028 busy SHALL be a registered output, asserted one cycle after any channel's request becomes nonzero.

Reset
REQ-029 On reset, the tick counters and phase SHALL be cleared to 0, so enc_a = 0 and enc_b = 0.
REQ-030 On reset, pos SHALL be set to 2^(POS_W-1) (0x80 for the default width), and busy and the acceleration state SHALL be cleared to 0.
REQ-031 Reset asserted mid-step SHALL abort the step, and the first step after release SHALL follow REQ-022.

Configuration
REQ-032 With macro QUAD_STEER_ACCEL_EN defined, each channel SHALL keep a 2-bit level and a 4-bit run counter, applying to digital mode only.
REQ-033 With QUAD_STEER_ACCEL_EN defined, the run counter SHALL increment per step, and 16 consecutive same-direction steps SHALL raise the level by one (saturating at 3) and clear the run counter.
REQ-034 With QUAD_STEER_ACCEL_EN defined, effdiv SHALL be max(clkdiv>>level, 1), and a request of 0, a reversal, or a mode change SHALL clear both the level and the run counter.
REQ-035 Without QUAD_STEER_ACCEL_EN, the acceleration logic SHALL be absent and REQ-023 SHALL apply in all modes, with the port list unchanged.

Verification
REQ-036 The bench SHALL check: reset, mode=0, clkdiv=4, right[0] held -> enc_a/enc_b of channel 0 go 00,01,11,10,00 at edges 4,8,12,16, and pos[0] goes 0x80->0x84.
REQ-037 The bench SHALL check: left[1] and right[1] both held -> channel 1 static, busy=0; release left[1] -> a step after 4 cycles.
REQ-038 The bench SHALL check: mode=1, target[0]=0x7D, clkdiv=1 -> three reverse steps on consecutive cycles, then pos[0]=0x7D held and busy deasserted.
REQ-039 The bench SHALL check: pos=0xFF, right held in digital mode -> next step gives pos 0x00 (wrap).
REQ-040 The bench SHALL check: reversal at counter=2 -> no step that cycle, and the first reverse step 4 cycles later.
REQ-041 The bench SHALL check: with QUAD_STEER_ACCEL_EN, clkdiv=16, right held -> step spacing 16 for steps 1-16, 8 for 17-32, 4 for 33-48, then 2, and release -> spacing returns to 16.

Source files
------------

// File: rtl/quad_steer_gen.sv
// rtl/quad_steer_gen.sv - multi-channel quadrature step generator with digital/absolute steering
// Optional acceleration: define QUAD_STEER_ACCEL_EN.
module quad_steer_gen #(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 16,
    parameter int POS_W    = 8
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [DIV_W-1:0]          clkdiv,
    input  logic [1:0]                mode,
    input  logic [CHANNELS-1:0]       left,
    input  logic [CHANNELS-1:0]       right,
    input  logic [CHANNELS*POS_W-1:0] target,
    output logic [CHANNELS-1:0]       enc_a,
    output logic [CHANNELS-1:0]       enc_b,
    output logic [CHANNELS*POS_W-1:0] pos,
    output logic                      busy
);

    localparam logic [POS_W-1:0] POS_RST = POS_W'(1) << (POS_W - 1);

    logic [1:0]          mode_q;
    logic                mode_chg;
    logic [CHANNELS-1:0] req_any;

    assign mode_chg = (mode != mode_q);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mode_q <= mode;
            busy   <= 1'b0;
        end else begin
            mode_q <= mode;
            busy   <= |req_any;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [1:0]       phase;
        logic [POS_W-1:0] p;
        logic [1:0]       dir_q;
        logic [POS_W-1:0] tgt;
        logic             up;
        logic             dn;
        logic             rev;
        logic [DIV_W-1:0] shifted;
        logic [DIV_W-1:0] effdiv_m1;

        assign tgt = target[g*POS_W +: POS_W];

        always_comb begin
            up = 1'b0;
            dn = 1'b0;
            case (mode)
                2'd0: begin
                    up = right[g] & ~left[g];
                    dn = left[g] & ~right[g];
                end
                2'd1: begin
                    up = (p < tgt);
                    dn = (p > tgt);
                end
                default: ;
            endcase
        end

        assign req_any[g] = up | dn;
        // dir_q holds last cycle's request as {up, dn}
        assign rev = (up & dir_q[0]) | (dn & dir_q[1]);

`ifdef QUAD_STEER_ACCEL_EN
        logic [1:0] level;
        logic [3:0] run;
        assign shifted = clkdiv >> level;
`else
        assign shifted = clkdiv;
`endif
        assign effdiv_m1 = (shifted == '0) ? '0 : shifted - 1'b1;

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                cnt   <= '0;
                phase <= 2'b00;
                p     <= POS_RST;
                dir_q <= 2'b00;
`ifdef QUAD_STEER_ACCEL_EN
                level <= 2'd0;
                run   <= 4'd0;
`endif
            end else begin
                dir_q <= {up, dn};
                if (mode_chg || !(up | dn)) begin
                    cnt <= '0;
`ifdef QUAD_STEER_ACCEL_EN
                    level <= 2'd0;
                    run   <= 4'd0;
`endif
                end else if (rev && cnt != '0) begin
                    cnt <= '0;
`ifdef QUAD_STEER_ACCEL_EN
                    level <= 2'd0;
                    run   <= 4'd0;
`endif
                end else if (cnt >= effdiv_m1) begin
                    cnt <= '0;
                    // Gray walk: up 00->01->11->10, down reversed
                    phase <= up ? {phase[0], ~phase[1]} : {~phase[0], phase[1]};
                    p     <= up ? p + 1'b1 : p - 1'b1;
`ifdef QUAD_STEER_ACCEL_EN
                    if (rev) begin
                        level <= 2'd0;
                        run   <= 4'd0;
                    end else if (mode == 2'd0) begin
                        if (run == 4'd15) begin
                            run <= 4'd0;
                            if (level != 2'd3)
                                level <= level + 1'b1;
                        end else begin
                            run <= run + 1'b1;
                        end
                    end
`endif
                end else begin
                    cnt <= cnt + 1'b1;
`ifdef QUAD_STEER_ACCEL_EN
                    if (rev) begin
                        level <= 2'd0;
                        run   <= 4'd0;
                    end
`endif
                end
            end
        end

        assign enc_a[g]               = phase[1];
        assign enc_b[g]               = phase[0];
        assign pos[g*POS_W +: POS_W]  = p;
    end

endmodule
